beam_readout: RTL and testbench

- Drains the beamformer result BRAM (the 2048 x 32 output signal RAM written by the delay beamformer) and presents its contents as a valid/ready stream for downstream transfer.
- It is the reader at the far end of the result-RAM write interface.
- Sequences read addresses, absorbs the BRAM's 1-cycle read latency, and applies backpressure without dropping or duplicating samples.

---
 rtl/beam_pkg.sv | 22 ++
 rtl/beam_fifo2.sv | 45 ++++
 rtl/beam_readout.sv | 143 ++++++++++++++
 tb/tb_beam_readout.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/beam_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : beam_pkg                                                |
// | Brief   : Constants and readout state encoding shared between the |
// |           delay beamformer and the result-RAM readout.            |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package beam_pkg;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 32;
  localparam int RAM_DEPTH  = 2048;
  localparam int RAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } readout_state_e;

endpackage
`default_nettype wire

// File: rtl/beam_fifo2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : beam_fifo2                                              |
// | Brief   : Two-entry synchronous FIFO, push and pop allowed in the |
// |           same cycle at any occupancy.                            |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module beam_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/beam_readout.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : beam_readout                                            |
// | Brief   : Drains the beamformer result RAM as a valid/ready       |
// |           stream. Define BEAM_READOUT_CHECKSUM_EN for a running   |
// |           sum of transferred beats on port checksum.              |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module beam_readout #(
  parameter int ADDR_W     = beam_pkg::ADDR_W,
  parameter int DATA_W     = beam_pkg::DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
`ifdef BEAM_READOUT_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              done
);

  import beam_pkg::*;

  localparam logic [1:0] c_st_idle    = IDLE;
  localparam logic [1:0] c_st_run     = RUN;
  localparam logic [1:0] c_st_drain   = DRAIN;
  localparam logic [1:0] c_fifo_depth = 2'(FIFO_DEPTH);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_issued;
  logic [ADDR_W:0]   r_popped;
  logic              r_inflight;
  logic              r_done;

  logic [1:0]        w_count;
  logic [1:0]        w_count_after_pop;
  logic [1:0]        w_credit_used;
  logic [DATA_W-1:0] w_head;
  logic              w_valid;
  logic              w_pop;
  logic              w_issue;
  logic              w_last;
  logic              w_start_ok;

  beam_fifo2 #(
    .WIDTH(DATA_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_inflight),
    .i_data (ram_q),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_count(w_count)
  );

  assign w_valid    = (w_count != 2'd0);
  assign w_pop      = w_valid & m_ready;
  assign w_start_ok = start && (r_state == c_st_idle);

  // Credits cover both FIFO entries and the read still inside the RAM pipeline.
  assign w_count_after_pop = w_count - {1'b0, w_pop};
  assign w_credit_used     = w_count_after_pop + {1'b0, r_inflight};
  assign w_issue = (r_state == c_st_run) && (r_issued < r_len) &&
                   (w_credit_used < c_fifo_depth);

  assign w_last = w_valid && (r_state != c_st_idle) && (r_popped == r_len - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_popped   <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) r_issued <= r_issued + 1'b1;
      if (w_pop)   r_popped <= r_popped + 1'b1;
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_base   <= base_addr;
            r_len    <= len;
            r_issued <= '0;
            r_popped <= '0;
            if (len == '0) r_done  <= 1'b1;
            else           r_state <= c_st_run;
          end
        end
        c_st_run: begin
          if (w_issue && (r_issued + 1'b1 == r_len)) r_state <= c_st_drain;
        end
        c_st_drain: begin
          // The final pop implies an empty FIFO and nothing in flight.
          if (w_pop && w_last) begin
            r_done  <= 1'b1;
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

`ifdef BEAM_READOUT_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (rst)             r_checksum <= '0;
    else if (w_start_ok) r_checksum <= '0;
    else if (w_pop)      r_checksum <= r_checksum + w_head;
  end

  assign checksum = r_checksum;
`endif

  assign ram_addr = r_base + r_issued[ADDR_W-1:0];
  assign ram_rden = w_issue;
  assign m_data   = w_head;
  assign m_valid  = w_valid;
  assign m_last   = w_last;
  assign busy     = (r_state != c_st_idle);
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_beam_readout.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_beam_readout                                         |
// | Brief   : Directed bench for beam_readout with a 1-cycle RAM.     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_beam_readout;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] base_addr;
  logic [11:0] len;
  logic [10:0] ram_addr;
  logic        ram_rden;
  logic [31:0] ram_q;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;
`ifdef BEAM_READOUT_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  beam_readout dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .ram_addr (ram_addr),
    .ram_rden (ram_rden),
    .ram_q    (ram_q),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy),
`ifdef BEAM_READOUT_CHECKSUM_EN
    .checksum (checksum),
`endif
    .done     (done)
  );

  logic [31:0] mem [0:2047];

  always @(posedge clk) if (ram_rden) ram_q <= mem[ram_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int          first_valid, last_beat_idx, done_idx, n_beats, done_cnt;
  int          data_err, last_err, stall_err, occ_err;
  logic        busy_at_done, busy_any;
  logic [31:0] cks_at_done;
  logic [10:0] addr_q[$];
  int          pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  // mode 0: m_ready held high; mode 1: m_ready follows pat. poke>=0 pulses start mid-run.
  task automatic run_rd(input logic [10:0] b, input logic [11:0] l, input int mode, input int poke);
    int          issued = 0;
    int          beats  = 0;
    logic        pv = 1'b0;
    logic        pnr = 1'b0;
    logic [31:0] pdata = '0;
    logic [10:0] a;
    first_valid = -1; last_beat_idx = -1; done_idx = -1; done_cnt = 0;
    data_err = 0; last_err = 0; stall_err = 0; occ_err = 0;
    busy_at_done = 1'b1; busy_any = 1'b0; cks_at_done = '0;
    addr_q.delete();
    @(negedge clk);
    base_addr = b; len = l; start = 1'b1; m_ready = 1'b1;
    for (int n = 0; n < int'(l) + 60; n++) begin
      @(negedge clk);
      start = (n == poke);
      if (n == poke) begin
        base_addr = b + 11'd7;
        len       = 12'd3;
      end
      m_ready = (mode == 0) ? 1'b1 : pat[n % 8][0];
      #1;
      if (busy) busy_any = 1'b1;
      if (ram_rden) begin
        issued++;
        addr_q.push_back(ram_addr);
      end
      if (m_valid && first_valid < 0) first_valid = n;
      if (m_last && !m_valid) last_err++;
      if (pv && pnr && (!m_valid || m_data !== pdata)) stall_err++;
      if (m_valid && m_ready) begin
        a = b + 11'(beats);
        if (m_data !== mem[a]) data_err++;
        if (m_last !== (beats == int'(l) - 1)) last_err++;
        if (m_last) last_beat_idx = n;
        beats++;
      end
      if (issued - beats > 2) occ_err++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx     = n;
          busy_at_done = busy;
`ifdef BEAM_READOUT_CHECKSUM_EN
          cks_at_done  = checksum;
`endif
        end
      end
      pv = m_valid; pnr = !m_ready; pdata = m_data;
      if (done_idx >= 0 && n >= done_idx + 3) break;
    end
    start   = 1'b0;
    n_beats = beats;
  endtask

  initial begin
    logic [10:0] exp_addr[6] = '{11'd2045, 11'd2046, 11'd2047, 11'd0, 11'd1, 11'd2};
    for (int i = 0; i < 2048; i++) mem[i] = 32'(i) + 32'h100;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rden",  {63'd0, ram_rden}, 64'd0);
    check("rst_valid", {63'd0, m_valid},  64'd0);
    check("rst_busy",  {63'd0, busy},     64'd0);
    check("rst_addr",  {53'd0, ram_addr}, 64'd0);

    // Plain readout, sink always ready
    run_rd(11'd0, 12'd8, 0, -1);
    check("t1_first_valid", 64'(first_valid), 64'd2);
    check("t1_beats",       64'(n_beats),     64'd8);
    check("t1_data",        64'(data_err),    64'd0);
    check("t1_last",        64'(last_err),    64'd0);
    check("t1_last_idx",    64'(last_beat_idx), 64'd9);
    check("t1_done_idx",    64'(done_idx),    64'd10);
    check("t1_done_cnt",    64'(done_cnt),    64'd1);
    check("t1_busy_done",   {63'd0, busy_at_done}, 64'd0);
`ifdef BEAM_READOUT_CHECKSUM_EN
    check("t1_checksum",    {32'd0, cks_at_done}, 64'h81C);
`endif

    // Backpressure plus an ignored start while busy
    run_rd(11'd0, 12'd8, 1, 4);
    check("t2_beats",    64'(n_beats),   64'd8);
    check("t2_data",     64'(data_err),  64'd0);
    check("t2_stall",    64'(stall_err), 64'd0);
    check("t2_occ",      64'(occ_err),   64'd0);
    check("t2_last",     64'(last_err),  64'd0);
    check("t2_done_cnt", 64'(done_cnt),  64'd1);
    repeat (4) @(negedge clk);
    #1;
    check("t2_idle_after", {62'd0, busy, m_valid}, 64'd0);

    // Address wrap at the top of the RAM
    run_rd(11'd2045, 12'd6, 0, -1);
    check("t3_naddr", 64'(addr_q.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_addr%0d", i), {53'd0, (i < addr_q.size()) ? addr_q[i] : 11'h7FF},
            {53'd0, exp_addr[i]});
    check("t3_beats", 64'(n_beats),  64'd6);
    check("t3_data",  64'(data_err), 64'd0);

    // Zero length: done only
    run_rd(11'd9, 12'd0, 0, -1);
    check("t4_no_valid", 64'(first_valid), -64'sd1);
    check("t4_done_idx", 64'(done_idx),    64'd0);
    check("t4_done_cnt", 64'(done_cnt),    64'd1);
    check("t4_busy",     {63'd0, busy_any}, 64'd0);

    // Reset with beat 3 of 8 pending and sink stalled
    @(negedge clk);
    base_addr = 11'd0; len = 12'd8; start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    m_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    check("t5_addr",  {53'd0, ram_addr}, 64'd0);
    check("t5_rden",  {63'd0, ram_rden}, 64'd0);
    check("t5_valid", {63'd0, m_valid},  64'd0);
    check("t5_last",  {63'd0, m_last},   64'd0);
    check("t5_data",  {32'd0, m_data},   64'd0);
    check("t5_busy",  {63'd0, busy},     64'd0);
    check("t5_done",  {63'd0, done},     64'd0);
    rst = 1'b0;
    run_rd(11'd16, 12'd4, 0, -1);
    check("t5b_beats",    64'(n_beats),     64'd4);
    check("t5b_data",     64'(data_err),    64'd0);
    check("t5b_first",    64'(first_valid), 64'd2);
    check("t5b_done_idx", 64'(done_idx),    64'd6);

    // Full-RAM readout from a non-zero base
    run_rd(11'd5, 12'd2048, 0, -1);
    check("t6_beats",    64'(n_beats),  64'd2048);
    check("t6_data",     64'(data_err), 64'd0);
    check("t6_last",     64'(last_err), 64'd0);
    check("t6_done_idx", 64'(done_idx), 64'd2050);

`ifdef BEAM_READOUT_CHECKSUM_EN
    for (int i = 0; i < 4; i++) mem[i] = 32'hFFFF_FFFF;
    run_rd(11'd0, 12'd4, 0, -1);
    check("t7_checksum", {32'd0, cks_at_done}, 64'hFFFF_FFFC);
    check("t7_beats",    64'(n_beats), 64'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
